// File: rtl/shared_buff_pkg.sv
// Shared types and defaults for the shared-buffer pop scheduler.
package shared_buff_pkg;

   localparam int unsigned WW_DEFAULT = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

endpackage

// File: rtl/shared_buff_pop_sched_rr_arbiter.sv
// Rotating-priority search: first request strictly after last, wrapping back to last itself.
module rr_arbiter #(
   parameter int unsigned Q  = 4,
   parameter int unsigned QW = (Q > 1) ? $clog2(Q) : 1
) (
   input  logic [Q-1:0]  req,
   input  logic [QW-1:0] last,
   output logic [Q-1:0]  grant
);

   logic          found;
   logic [QW-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 1; i <= Q; i++) begin
         idx = QW'((32'(last) + i) % Q);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/shared_buff_pop_sched.sv
// Weighted round-robin pop scheduler for a shared multi-queue buffer with a one-entry output register.
module shared_buff_pop_sched
   import shared_buff_pkg::*;
#(
   parameter int unsigned DW = 16,
   parameter int unsigned Q  = 4,
   parameter int unsigned WW = WW_DEFAULT,
   localparam int unsigned QW = (Q > 1) ? $clog2(Q) : 1
) (
   input  logic            clk,
   input  logic            arst,
   input  logic            en,
   input  logic [Q*WW-1:0] cfg_weight,
   input  logic [Q-1:0]    valid,
   input  logic [DW-1:0]   data_out,
   output logic            pop,
   output logic [Q-1:0]    pop_sel,
   output logic            out_valid,
   output logic [DW-1:0]   out_data,
   output logic [QW-1:0]   out_qid,
   input  logic            out_ready
);

   state_t        state, state_nxt;
   logic [QW-1:0] cur, cur_nxt;
   logic [WW-1:0] cnt, cnt_nxt;

   logic [Q-1:0]  elig;
   logic [Q-1:0]  arb_gnt;
   logic [Q-1:0]  gnt;
   logic [QW-1:0] gnt_idx;
   logic [WW-1:0] w_cur;
   logic          burst_cont;
   logic          space;

   // Eligibility and current-queue weight, re-sampled every cycle
   always_comb begin
      elig  = '0;
      w_cur = '0;
      for (int unsigned i = 0; i < Q; i++) begin
         elig[i] = valid[i] && (cfg_weight[i*WW +: WW] != '0);
         if (QW'(i) == cur) w_cur = cfg_weight[i*WW +: WW];
      end
   end

   rr_arbiter #(
      .Q  (Q),
      .QW (QW)
   ) u_arb (
      .req   (elig),
      .last  (cur),
      .grant (arb_gnt)
   );

   // State register
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state <= IDLE;
         cur   <= QW'(Q - 1);
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cur   <= cur_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Output decode: an ended burst falls through to re-arbitration in the same cycle
   always_comb begin
      burst_cont = (state == BURST) && valid[cur] && (cnt < w_cur);
      gnt        = burst_cont ? (Q'(1) << cur) : arb_gnt;
      space      = !out_valid || out_ready;
      pop        = !arst && en && space && (gnt != '0);
      pop_sel    = pop ? gnt : '0;
      gnt_idx    = '0;
      for (int unsigned i = 0; i < Q; i++) begin
         if (gnt[i]) gnt_idx = QW'(i);
      end
   end

   // Next-state; en low freezes state, cur and cnt
   always_comb begin
      state_nxt = state;
      cur_nxt   = cur;
      cnt_nxt   = cnt;
      if (en) begin
         if (burst_cont) begin
            if (pop) cnt_nxt = cnt + WW'(1);
         end else if (pop) begin
            state_nxt = BURST;
            cur_nxt   = gnt_idx;
            cnt_nxt   = WW'(1);
         end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      end
   end

   // One-entry output register; word is held while stalled
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_qid   <= '0;
      end else if (pop) begin
         out_valid <= 1'b1;
         out_data  <= data_out;
         out_qid   <= gnt_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shared_buff_pop_sched.sv
// Directed table-driven bench for shared_buff_pop_sched with a stub buffer head model.
module tb_shared_buff_pop_sched;

   localparam int unsigned DW = 16;
   localparam int unsigned Q  = 4;
   localparam int unsigned WW = 4;

   logic          clk;
   logic          arst;
   logic          en;
   logic [15:0]   cfg_weight;
   logic [3:0]    valid;
   logic [15:0]   data_out;
   logic          pop;
   logic [3:0]    pop_sel;
   logic          out_valid;
   logic [15:0]   out_data;
   logic [1:0]    out_qid;
   logic          out_ready;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic        rst;
      logic        en;
      logic        rdy;
      logic [3:0]  vld;
      logic [15:0] wgt;
      logic        e_pop;
      logic [3:0]  e_sel;
      logic        e_ov;
      logic [1:0]  e_qid;
   } vec_t;

   vec_t vecs[$];

   shared_buff_pop_sched #(
      .DW (DW),
      .Q  (Q),
      .WW (WW)
   ) dut (
      .clk        (clk),
      .arst       (arst),
      .en         (en),
      .cfg_weight (cfg_weight),
      .valid      (valid),
      .data_out   (data_out),
      .pop        (pop),
      .pop_sel    (pop_sel),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_qid    (out_qid),
      .out_ready  (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] qdata(input int q);
      return 16'((q + 1) * 16'h1000 + 16'h00AA);
   endfunction

   // Buffer head word, addressed combinationally by pop_sel
   always_comb begin
      data_out = '0;
      for (int i = 0; i < 4; i++) begin
         if (pop_sel[i]) data_out = qdata(i);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic e, input logic rdy, input logic [3:0] vld,
                      input logic [15:0] wgt, input logic p, input logic [3:0] sel,
                      input logic ov, input logic [1:0] qid);
      vec_t v;
      v.rst = rst; v.en = e; v.rdy = rdy; v.vld = vld; v.wgt = wgt;
      v.e_pop = p; v.e_sel = sel; v.e_ov = ov; v.e_qid = qid;
      vecs.push_back(v);
   endtask

   initial begin
      arst       = 1'b1;
      en         = 1'b0;
      cfg_weight = '0;
      valid      = '0;
      out_ready  = 1'b0;

      // Equal weights, all valid: plain round robin
      add(1,1,1,4'hF,16'h1111, 0,4'h0,0,0);
      add(0,1,1,4'hF,16'h1111, 1,4'h1,0,0);
      add(0,1,1,4'hF,16'h1111, 1,4'h2,1,0);
      add(0,1,1,4'hF,16'h1111, 1,4'h4,1,1);
      add(0,1,1,4'hF,16'h1111, 1,4'h8,1,2);
      add(0,1,1,4'hF,16'h1111, 1,4'h1,1,3);
      // q0 weight 3, q1 weight 1
      add(1,1,1,4'h3,16'h0013, 0,4'h0,0,0);
      add(0,1,1,4'h3,16'h0013, 1,4'h1,0,0);
      add(0,1,1,4'h3,16'h0013, 1,4'h1,1,0);
      add(0,1,1,4'h3,16'h0013, 1,4'h1,1,0);
      add(0,1,1,4'h3,16'h0013, 1,4'h2,1,0);
      add(0,1,1,4'h3,16'h0013, 1,4'h1,1,1);
      add(0,1,1,4'h3,16'h0013, 1,4'h1,1,0);
      add(0,1,1,4'h3,16'h0013, 1,4'h1,1,0);
      add(0,1,1,4'h3,16'h0013, 1,4'h2,1,0);
      add(0,1,1,4'h3,16'h0013, 1,4'h1,1,1);
      // Zero weight disables a valid queue
      add(1,1,1,4'h4,16'h1011, 0,4'h0,0,0);
      add(0,1,1,4'h4,16'h1011, 0,4'h0,0,0);
      add(0,1,1,4'h4,16'h1011, 0,4'h0,0,0);
      add(0,1,1,4'h4,16'h1011, 0,4'h0,0,0);
      // en low blocks pops, drains output, freezes FSM
      add(1,1,1,4'hF,16'h1111, 0,4'h0,0,0);
      add(0,0,1,4'hF,16'h1111, 0,4'h0,0,0);
      add(0,1,1,4'hF,16'h1111, 1,4'h1,0,0);
      add(0,0,1,4'hF,16'h1111, 0,4'h0,1,0);
      add(0,0,1,4'hF,16'h1111, 0,4'h0,0,0);
      add(0,1,1,4'hF,16'h1111, 1,4'h2,0,0);
      // Downstream stall for three cycles after the first pop
      add(1,1,1,4'hF,16'h1111, 0,4'h0,0,0);
      add(0,1,1,4'hF,16'h1111, 1,4'h1,0,0);
      add(0,1,0,4'hF,16'h1111, 0,4'h0,1,0);
      add(0,1,0,4'hF,16'h1111, 0,4'h0,1,0);
      add(0,1,0,4'hF,16'h1111, 0,4'h0,1,0);
      add(0,1,1,4'hF,16'h1111, 1,4'h2,1,0);
      add(0,1,1,4'hF,16'h1111, 1,4'h4,1,1);
      // valid[1] drops mid-burst (weight 4, two words served)
      add(1,1,1,4'h2,16'h1140, 0,4'h0,0,0);
      add(0,1,1,4'h2,16'h1140, 1,4'h2,0,0);
      add(0,1,1,4'h2,16'h1140, 1,4'h2,1,1);
      add(0,1,1,4'hC,16'h1140, 1,4'h4,1,1);
      add(0,1,1,4'hC,16'h1140, 1,4'h8,1,2);
      // Weight lowered below cnt ends the burst at once
      add(1,1,1,4'h3,16'h0013, 0,4'h0,0,0);
      add(0,1,1,4'h3,16'h0013, 1,4'h1,0,0);
      add(0,1,1,4'h3,16'h0011, 1,4'h2,1,0);
      // Single eligible queue: back-to-back bursts
      add(1,1,1,4'h4,16'h0200, 0,4'h0,0,0);
      add(0,1,1,4'h4,16'h0200, 1,4'h4,0,0);
      add(0,1,1,4'h4,16'h0200, 1,4'h4,1,2);
      add(0,1,1,4'h4,16'h0200, 1,4'h4,1,2);
      add(0,1,1,4'h4,16'h0200, 1,4'h4,1,2);
      // Reset with a held word restarts from queue 0
      add(1,1,1,4'hF,16'h1111, 0,4'h0,0,0);
      add(0,1,1,4'hF,16'h1111, 1,4'h1,0,0);
      add(0,1,1,4'hF,16'h1111, 1,4'h2,1,0);
      add(0,1,0,4'hF,16'h1111, 0,4'h0,1,1);
      add(1,1,0,4'hF,16'h1111, 0,4'h0,0,0);
      add(0,1,1,4'hF,16'h1111, 1,4'h1,0,0);

      @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         arst       = vecs[i].rst;
         en         = vecs[i].en;
         out_ready  = vecs[i].rdy;
         valid      = vecs[i].vld;
         cfg_weight = vecs[i].wgt;
         @(negedge clk);
         chk($sformatf("v%0d_pop", i),     32'(pop),       32'(vecs[i].e_pop));
         chk($sformatf("v%0d_pop_sel", i), 32'(pop_sel),   32'(vecs[i].e_sel));
         chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
         if (vecs[i].e_ov) begin
            chk($sformatf("v%0d_out_qid", i),  32'(out_qid),  32'(vecs[i].e_qid));
            chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(qdata(int'(vecs[i].e_qid))));
         end else if (vecs[i].rst) begin
            chk($sformatf("v%0d_rst_qid", i),  32'(out_qid),  32'h0);
            chk($sformatf("v%0d_rst_data", i), 32'(out_data), 32'h0);
         end
         @(posedge clk);
         #1;
      end

      // Short mid-cycle reset pulse between clock edges
      arst = 1'b1; en = 1'b1; out_ready = 1'b0; valid = 4'hF; cfg_weight = 16'h1111;
      @(posedge clk);
      #1;
      arst = 1'b0;
      @(posedge clk);
      #1;
      arst = 1'b0;
      chk("pulse_pre_valid", 32'(out_valid), 32'h1);
      chk("pulse_pre_data",  32'(out_data),  32'(qdata(0)));
      #1 arst = 1'b1;
      #1;
      chk("pulse_valid", 32'(out_valid), 32'h0);
      chk("pulse_data",  32'(out_data),  32'h0);
      chk("pulse_pop",   32'(pop),       32'h0);
      #1 arst = 1'b0;
      @(negedge clk);
      chk("pulse_restart_sel", 32'(pop_sel), 32'h1);

      // Stall then release: next pop must appear in the release cycle, within a bound
      @(posedge clk);
      #1;
      begin
         int waited = 0;
         bit seen   = 1'b0;
         out_ready = 1'b1;
         while (!seen && waited < 8) begin
            @(negedge clk);
            if (pop) seen = 1'b1;
            else begin
               @(posedge clk);
               #1;
               waited++;
            end
         end
         chk("resume_seen",   32'(seen),    32'h1);
         chk("resume_cycles", 32'(waited),  32'h0);
         chk("resume_sel",    32'(pop_sel), 32'h2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
